// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one reg-reg / reg-imm ALU operation at a time (IDLE->READ->EXEC->WB).
// Latency: handshake at edge N, register write enable high in cycle N+3; one op per 4 cycles.
// Backpressure: cmd_ready low while an op is in flight (ALU_SEQ_CMD_FIFO_EN: low only when queue full).
module alu_op_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [4:0]  cmd_rs,
    input  logic [4:0]  cmd_rt,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_shft,
    input  logic        cmd_imm_sel,
    input  logic [31:0] cmd_imm,
    output logic [4:0]  rf_read1,
    output logic [4:0]  rf_read2,
    input  logic [31:0] rf_out1,
    input  logic [31:0] rf_out2,
    output logic        rf_wrtEn,
    output logic [4:0]  rf_wrtAdd,
    output logic [31:0] rf_data,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [3:0]  alu_op,
    output logic [4:0]  alu_shft,
    input  logic [31:0] alu_Result,
    input  logic        alu_overflow,
    input  logic        alu_lessthan,
    output logic        busy,
    output logic        done,
    output logic        status_overflow,
    output logic        status_lessthan
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] WB   = 2'd3;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shft;
        logic        imm_sel;
        logic [31:0] imm;
    } cmd_t;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [1:0] state;
    cmd_t       cmd_in;
    cmd_t       cur;
    logic       take;
    cmd_t       take_dat;
    logic       is_addsub;
    logic       is_cmp;
    logic       ovf_q;
    logic       lt_q;
    logic [31:0] wr_dat;

    assign cmd_in = '{op: cmd_op, rs: cmd_rs, rt: cmd_rt, rd: cmd_rd,
                      shft: cmd_shft, imm_sel: cmd_imm_sel, imm: cmd_imm};

`ifdef ALU_SEQ_CMD_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    cmd_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_nxt;
    cmd_t        pop_dat;
    logic        pop_vld;
    logic        pop_vld_nxt;
    logic        push;
    logic        pop;

    // Queue bookkeeping: push whenever not full, pop one entry per idle slot (registered read, no bypass)
    always_comb begin
        push        = cmd_valid && cmd_ready;
        pop         = (state == IDLE) && !pop_vld && (cnt != '0);
        take        = (state == IDLE) && pop_vld;
        take_dat    = pop_dat;
        cnt_nxt     = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        pop_vld_nxt = pop || (pop_vld && !take);
    end

    // Queue storage; contents need no reset since the count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    // Pointers, occupancy, popped entry and the ready/busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            pop_dat   <= '0;
            pop_vld   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                pop_dat <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            cnt       <= cnt_nxt;
            pop_vld   <= pop_vld_nxt;
            cmd_ready <= (cnt_nxt != (AW+1)'(FIFO_DEPTH));
            busy      <= take || (state == READ) || (state == EXEC)
                         || (cnt_nxt != '0) || pop_vld_nxt;
        end
    end
`else
    assign take     = (state == IDLE) && cmd_valid && cmd_ready;
    assign take_dat = cmd_in;

    // Ready drops on acceptance and returns as WB retires; busy is its complement over the op lifetime
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end else if (take) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
        end else if (state == WB) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
        end
    end
`endif

    // Flag qualification: an X or stray flag from the ALU only matters for the ops that define it
    always_comb begin
        is_addsub = (cur.op == 4'd0) || (cur.op == 4'd1);
        is_cmp    = (cur.op == 4'd7) || (cur.op == 4'd8);
        ovf_q     = 1'b0;
        if (is_addsub && alu_overflow) begin
            ovf_q = 1'b1;
        end
        lt_q = 1'b0;
        if (alu_lessthan) begin
            lt_q = 1'b1;
        end
        wr_dat = is_cmp ? {31'b0, lt_q} : alu_Result;
    end

    // Main sequencer: latch command, register operands, capture result, issue the single write
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cur             <= '0;
            rf_read1        <= '0;
            rf_read2        <= '0;
            alu_A           <= '0;
            alu_B           <= '0;
            alu_op          <= '0;
            alu_shft        <= '0;
            rf_wrtEn        <= 1'b0;
            rf_wrtAdd       <= '0;
            rf_data         <= '0;
            done            <= 1'b0;
            status_overflow <= 1'b0;
            status_lessthan <= 1'b0;
        end else begin
            rf_wrtEn <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        cur      <= take_dat;
                        rf_read1 <= take_dat.rs;
                        rf_read2 <= take_dat.rt;
                        state    <= READ;
                    end
                end
                READ: begin
                    alu_A    <= rf_out1;
                    alu_B    <= cur.imm_sel ? cur.imm : rf_out2;
                    alu_op   <= cur.op;
                    alu_shft <= cur.shft;
                    state    <= EXEC;
                end
                EXEC: begin
                    rf_wrtAdd <= cur.rd;
                    rf_data   <= wr_dat;
                    rf_wrtEn  <= (cur.rd != 5'd0) && !ovf_q;
                    done      <= 1'b1;
                    if (ovf_q) begin
                        status_overflow <= 1'b1;
                    end
                    if (is_cmp) begin
                        status_lessthan <= lt_q;
                    end
                    state <= WB;
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
